prbs_checker: RTL and testbench
===============================

# prbs_checker

Receive-side PRBS7 checker for the bit error rate measurement FPGA, directly downstream of the PRBS generator (optionally through the fiber link). Self-synchronises to the incoming x^7 + x^6 + 1 bitstream, declares lock, then compares each received bit against a free-running local LFSR. Accumulates total-bit and error-bit counts for the control logic to compute BER.

## Interface
- LOCK_COUNT, 16: consecutive correct predictions in HUNT required to declare lock (range 1..255)
- LOSS_WINDOW, 64: bits per lock-loss observation window (power of two, 8..1024)
- LOSS_THRESH, 8: errors within one window that force lock loss (1..LOSS_WINDOW)
- CNT_WIDTH, 32: width of bit and error counters

- clk  input  1  100 MHz system clock, one bit sampled per cycle
- rst  input  1  synchronous, active-high reset
- bitin  input  1  received PRBS bit
- clear  input  1  synchronous counter clear; lock state is unaffected
- locked  output  1  high while in LOCKED
- error_pulse  output  1  one-cycle pulse per counted bit error
- bit_count  output  CNT_WIDTH  bits compared while locked, saturating
- error_count  output  CNT_WIDTH  mismatches counted while locked, saturating

## Operation
- States: SEED, HUNT, LOCKED.
- SEED: shift bitin into 7-bit register rx. After 7 bits, go to HUNT with a match counter of 0.
- HUNT:
  - Predicted bit = rx[6] ^ rx[5]. Compare it with bitin, then shift bitin into rx.
  - Match: increment the match counter. When it reaches LOCK_COUNT, copy the updated rx into local LFSR lfsr and go to LOCKED.
  - Mismatch: reset the match counter to 0 and stay in HUNT. rx is already updated, so no re-seed is needed.
- LOCKED:
  - Expected bit = lfsr[6] ^ lfsr[5]. lfsr shifts in the expected bit, never bitin, so one flipped input bit counts exactly one error.
  - Every bit increments bit_count.
  - Mismatch: increment error_count and assert error_pulse.
- Counters saturate at all-ones and never wrap.
- clear:
  - Zeroes both counters.
  - If clear coincides with a compared bit, clear wins and that bit is not counted.
  - error_pulse still fires for that bit.
- rst:
  - Next state SEED. rx = 7'h00, lfsr = 7'h00, match counter = 0, window counters = 0.
  - All outputs 0.
  - Any state mid-operation is abandoned immediately.
- All-zero lock guard: if rx is 7'h00 when the match counter would reach LOCK_COUNT, stay in HUNT and reset the match counter. PRBS7 never contains seven zeros.

## Timing
- All outputs are registered.
- bitin sampled at edge N → error_pulse and counter updates visible after edge N+1.
- locked rises the cycle after the edge at which the match counter reaches LOCK_COUNT.
- Clean stream from reset release: locked high after 7 + LOCK_COUNT sampled bits (23 with defaults).
- Lock-loss window:
  - A window bit counter and a window error counter run only in LOCKED.
  - At the end of each LOSS_WINDOW bits, both window counters reset.
  - If the window error counter reaches LOSS_THRESH, go to SEED on that edge. locked falls on the next cycle.
  - bit_count and error_count hold their values; they are not cleared.
- The bit that triggers lock loss is counted.

## Configuration
- PRBS_CHECKER_LOSS_EN defined: lock-loss window logic is compiled in, as described above.
- PRBS_CHECKER_LOSS_EN undefined: window logic is removed. LOCKED is exited only by rst. LOSS_WINDOW and LOSS_THRESH are ignored.

## Structure
- Package prbs_pkg holds:
  - PRBS7 constants: width 7, taps 6 and 5.
  - The checker state enum typedef {SEED, HUNT, LOCKED}.
  - A function prbs7_next(word) returning word[6] ^ word[5].
- One sub-module, prbs7_lfsr: 7-bit LFSR with load enable, load value and step enable. Used for lfsr in LOCKED; reusable by the generator side.
- The checker top holds the FSM, match counter, window logic and saturating counters.

## Test plan
- Clean PRBS7 stream seeded 7'h7f, defaults → locked high after 23 bits. After a further 10000 bits: bit_count = 10000, error_count = 0, no error_pulse.
- Locked stream with one bit flipped every 1000 bits → error_count increments by exactly 1 per flip (10 after 10000 bits), with a one-cycle error_pulse each time. locked stays high.
- Random bitin during HUNT, then a valid PRBS7 stream → locked only after 16 consecutive correct predictions. Constant 0 input never locks.
- PRBS_CHECKER_LOSS_EN defined, 8 flips within 64 locked bits → locked falls, FSM re-seeds, counters hold, relock after 23 clean bits. With the macro undefined → locked stays high.
- clear asserted on the same cycle as a flipped bit → both counters read 0 next cycle and error_pulse still fires. Counters preset near all-ones via CNT_WIDTH=8 → saturate at 255.
- rst asserted mid-LOCKED → the next cycle shows locked = 0, counters = 0, state SEED.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS7 (x^7 + x^6 + 1) definitions for the BER checker and generator:
// polynomial constants, checker state encoding and the feedback function.
package prbs_pkg;

  localparam int PRBS7_WIDTH = 7;
  localparam int PRBS7_TAP_A = 6;
  localparam int PRBS7_TAP_B = 5;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  function automatic logic prbs7_next(input logic [PRBS7_WIDTH-1:0] word);
    return word[PRBS7_TAP_A] ^ word[PRBS7_TAP_B];
  endfunction

endpackage

// File: rtl/prbs7_lfsr.sv
// Free-running 7-bit PRBS7 LFSR with parallel load; next_bit is the bit the
// register will shift in on its next step (the sequence output).
module prbs7_lfsr
  import prbs_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [PRBS7_WIDTH-1:0] load_val,
  input  logic                   step,
  output logic                   next_bit
);

  logic [PRBS7_WIDTH-1:0] state;

  // Load takes priority so the checker can hand over its seed on the lock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= {state[PRBS7_WIDTH-2:0], prbs7_next(state)};
    end
  end

  assign next_bit = prbs7_next(state);

endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS7 checker: self-seeds, hunts for lock, then counts compared
// bits and errors against a free-running local LFSR. Define PRBS_CHECKER_LOSS_EN
// to compile in the windowed lock-loss detector.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT  = 16,
  parameter int LOSS_WINDOW = 64,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_WIDTH   = 32
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bitin,
  input  logic                 clear,
  output logic                 locked,
  output logic                 error_pulse,
  output logic [CNT_WIDTH-1:0] bit_count,
  output logic [CNT_WIDTH-1:0] error_count
);

  localparam logic [7:0] LOCK_TARGET = 8'(LOCK_COUNT);

  generate
    if (LOCK_COUNT < 1 || LOCK_COUNT > 255 || LOSS_WINDOW < 8 || LOSS_WINDOW > 1024 ||
        LOSS_THRESH < 1 || LOSS_THRESH > LOSS_WINDOW || CNT_WIDTH < 1) begin : g_bad_cfg
      $error("prbs_checker: parameter out of range");
    end
  endgenerate

  chk_state_t             state, state_nx;
  logic [PRBS7_WIDTH-1:0] rx, rx_nx;
  logic [2:0]             seed_cnt, seed_cnt_nx;
  logic [7:0]             match_cnt, match_cnt_nx;
  logic                   lfsr_load, lfsr_step;
  logic                   expected_bit;
  logic                   cmp_bit, bit_err;
  logic                   loss_hit;

  prbs7_lfsr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (rx_nx),
    .step     (lfsr_step),
    .next_bit (expected_bit)
  );

  assign cmp_bit = (state == LOCKED);
  assign bit_err = cmp_bit && (expected_bit != bitin);

`ifdef PRBS_CHECKER_LOSS_EN
  localparam int WIN_W  = $clog2(LOSS_WINDOW);
  localparam int WERR_W = WIN_W + 1;
  localparam logic [WERR_W-1:0] THRESH = WERR_W'(LOSS_THRESH);

  logic [WIN_W-1:0]  win_bits;
  logic [WERR_W-1:0] win_errs, win_errs_inc;

  assign win_errs_inc = win_errs + WERR_W'(bit_err);
  assign loss_hit     = bit_err && (win_errs_inc == THRESH);

  // Window counters only run while locked; the window wraps naturally because
  // LOSS_WINDOW is a power of two.
  always_ff @(posedge clk) begin
    if (rst || !cmp_bit || loss_hit) begin
      win_bits <= '0;
      win_errs <= '0;
    end else if (win_bits == '1) begin
      win_bits <= '0;
      win_errs <= '0;
    end else begin
      win_bits <= win_bits + WIN_W'(1);
      win_errs <= win_errs_inc;
    end
  end
`else
  assign loss_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEED;
      rx        <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
    end else begin
      state     <= state_nx;
      rx        <= rx_nx;
      seed_cnt  <= seed_cnt_nx;
      match_cnt <= match_cnt_nx;
    end
  end

  // An all-zero rx would lock the local LFSR into its stuck state, so refuse it.
  always_comb begin
    state_nx     = state;
    rx_nx        = rx;
    seed_cnt_nx  = seed_cnt;
    match_cnt_nx = match_cnt;
    lfsr_load    = 1'b0;
    lfsr_step    = 1'b0;
    case (state)
      SEED: begin
        rx_nx = {rx[PRBS7_WIDTH-2:0], bitin};
        if (seed_cnt == 3'd6) begin
          seed_cnt_nx  = '0;
          match_cnt_nx = '0;
          state_nx     = HUNT;
        end else begin
          seed_cnt_nx = seed_cnt + 3'd1;
        end
      end
      HUNT: begin
        rx_nx = {rx[PRBS7_WIDTH-2:0], bitin};
        if (prbs7_next(rx) == bitin) begin
          if (match_cnt + 8'd1 == LOCK_TARGET) begin
            match_cnt_nx = '0;
            if (rx_nx != '0) begin
              lfsr_load = 1'b1;
              state_nx  = LOCKED;
            end
          end else begin
            match_cnt_nx = match_cnt + 8'd1;
          end
        end else begin
          match_cnt_nx = '0;
        end
      end
      LOCKED: begin
        lfsr_step = 1'b1;
        if (loss_hit) begin
          seed_cnt_nx = '0;
          state_nx    = SEED;
        end
      end
      default: begin
        state_nx = SEED;
      end
    endcase
  end

  // Clear beats a same-cycle compare; counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked      <= 1'b0;
      error_pulse <= 1'b0;
      bit_count   <= '0;
      error_count <= '0;
    end else begin
      locked      <= (state_nx == LOCKED);
      error_pulse <= bit_err;
      if (clear) begin
        bit_count   <= '0;
        error_count <= '0;
      end else if (cmp_bit) begin
        if (bit_count != '1) begin
          bit_count <= bit_count + CNT_WIDTH'(1);
        end
        if (bit_err && (error_count != '1)) begin
          error_count <= error_count + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed self-checking bench for prbs_checker; a second instance with an
// 8-bit counter width exercises saturation on the same stimulus.
module tb_prbs_checker;
  import prbs_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        bitin;
  logic        clear;
  logic        locked, error_pulse;
  logic [31:0] bit_count, error_count;
  logic        locked8, error_pulse8;
  logic [7:0]  bit_count8, error_count8;

  int          errors = 0;
  int          checks = 0;
  logic [6:0]  gen;
  int          pulses;
  int          since_lock;
  bit          track;
  int          exp_bits;

  prbs_checker dut (
    .clk         (clk),
    .rst         (rst),
    .bitin       (bitin),
    .clear       (clear),
    .locked      (locked),
    .error_pulse (error_pulse),
    .bit_count   (bit_count),
    .error_count (error_count)
  );

  prbs_checker #(.CNT_WIDTH(8)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .bitin       (bitin),
    .clear       (clear),
    .locked      (locked8),
    .error_pulse (error_pulse8),
    .bit_count   (bit_count8),
    .error_count (error_count8)
  );

  always #5 clk = ~clk;

  task automatic next_gen(output logic b);
    b   = gen[6] ^ gen[5];
    gen = {gen[5:0], b};
  endtask

  task automatic send_bit(input logic b);
    bitin = b;
    @(posedge clk);
    #1;
    if (error_pulse) pulses++;
    if (track) since_lock++;
  endtask

  task automatic send_prbs(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      next_gen(b);
      send_bit(b);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    track = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    clear = 1'b0;
    bitin = 1'b0;
    track = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %b want 0", locked); end
    checks++; if (error_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulse: got %b want 0", error_pulse); end
    checks++; if (bit_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_bits: got %0d want 0", bit_count); end
    checks++; if (error_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_errs: got %0d want 0", error_count); end
    checks++; if (dut.state !== SEED) begin errors++; $display("[TB] FAIL reset_state: got %0d want SEED", dut.state); end
    rst = 1'b0;
  endtask

  task automatic test_clean_lock();
    gen    = 7'h7f;
    pulses = 0;
    send_prbs(22);
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL lock_early: got %b want 0 after 22 bits", locked); end
    send_prbs(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL lock_23: got %b want 1 after 23 bits", locked); end
    checks++; if (bit_count !== 32'd0) begin errors++; $display("[TB] FAIL lock_bits0: got %0d want 0", bit_count); end
    track      = 1'b1;
    since_lock = 0;
    send_prbs(10000);
    checks++; if (bit_count !== 32'd10000) begin errors++; $display("[TB] FAIL clean_bits: got %0d want 10000", bit_count); end
    checks++; if (error_count !== 32'd0) begin errors++; $display("[TB] FAIL clean_errs: got %0d want 0", error_count); end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL clean_pulses: got %0d want 0", pulses); end
    checks++; if (bit_count8 !== 8'd255) begin errors++; $display("[TB] FAIL sat_bits8: got %0d want 255", bit_count8); end
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL clean_locked: got %b want 1", locked); end
  endtask

  task automatic test_flips();
    logic b;
    clear = 1'b1;
    send_prbs(1);
    clear = 1'b0;
    checks++; if (bit_count !== 32'd0) begin errors++; $display("[TB] FAIL clear_bits: got %0d want 0", bit_count); end
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      send_prbs(499);
      next_gen(b);
      send_bit(~b);
      checks++; if (error_pulse !== 1'b1) begin errors++; $display("[TB] FAIL flip_pulse%0d: got %b want 1", k, error_pulse); end
      send_prbs(1);
      checks++; if (error_pulse !== 1'b0) begin errors++; $display("[TB] FAIL flip_pulse_end%0d: got %b want 0", k, error_pulse); end
      send_prbs(499);
    end
    checks++; if (bit_count !== 32'd10000) begin errors++; $display("[TB] FAIL flip_bits: got %0d want 10000", bit_count); end
    checks++; if (error_count !== 32'd10) begin errors++; $display("[TB] FAIL flip_errs: got %0d want 10", error_count); end
    checks++; if (pulses !== 10) begin errors++; $display("[TB] FAIL flip_pulses: got %0d want 10", pulses); end
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL flip_locked: got %b want 1", locked); end
    checks++; if (error_count8 !== 8'd10) begin errors++; $display("[TB] FAIL flip_errs8: got %0d want 10", error_count8); end
    checks++; if (bit_count8 !== 8'd255) begin errors++; $display("[TB] FAIL flip_bits8: got %0d want 255", bit_count8); end
  endtask

  task automatic test_clear_on_error();
    logic b;
    next_gen(b);
    clear = 1'b1;
    send_bit(~b);
    clear = 1'b0;
    checks++; if (error_pulse !== 1'b1) begin errors++; $display("[TB] FAIL clr_pulse: got %b want 1", error_pulse); end
    checks++; if (bit_count !== 32'd0) begin errors++; $display("[TB] FAIL clr_bits: got %0d want 0", bit_count); end
    checks++; if (error_count !== 32'd0) begin errors++; $display("[TB] FAIL clr_errs: got %0d want 0", error_count); end
    send_prbs(1);
    checks++; if (bit_count !== 32'd1) begin errors++; $display("[TB] FAIL clr_next_bits: got %0d want 1", bit_count); end
    checks++; if (error_pulse !== 1'b0) begin errors++; $display("[TB] FAIL clr_next_pulse: got %b want 0", error_pulse); end
  endtask

  task automatic test_loss_window();
    logic b;
    int   n;
    n        = (64 - (since_lock % 64)) % 64;
    send_prbs(n);
    exp_bits = 1 + n;
    for (int k = 0; k < 7; k++) begin
      next_gen(b);
      send_bit(~b);
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL loss_7flips: got %b want 1", locked); end
    next_gen(b);
    send_bit(~b);
    exp_bits = exp_bits + 8;
    checks++; if (error_count !== 32'd8) begin errors++; $display("[TB] FAIL loss_errs: got %0d want 8", error_count); end
    checks++; if (bit_count !== 32'(exp_bits)) begin errors++; $display("[TB] FAIL loss_bits: got %0d want %0d", bit_count, exp_bits); end
`ifdef PRBS_CHECKER_LOSS_EN
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL loss_locked: got %b want 0", locked); end
    checks++; if (dut.state !== SEED) begin errors++; $display("[TB] FAIL loss_state: got %0d want SEED", dut.state); end
    send_prbs(22);
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL relock_early: got %b want 0", locked); end
    send_prbs(1);
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL relock_23: got %b want 1", locked); end
    checks++; if (bit_count !== 32'(exp_bits)) begin errors++; $display("[TB] FAIL relock_bits_hold: got %0d want %0d", bit_count, exp_bits); end
    checks++; if (error_count !== 32'd8) begin errors++; $display("[TB] FAIL relock_errs_hold: got %0d want 8", error_count); end
`else
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL noloss_locked: got %b want 1", locked); end
    send_prbs(64);
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL noloss_stay: got %b want 1", locked); end
`endif
  endtask

  task automatic test_hunt();
    logic [6:0] mrx;
    int         run, nbits;
    bit         exp_lock;
    logic       b;
    pulse_reset();
    mrx = 7'h00; run = 0; nbits = 0; exp_lock = 1'b0;
    for (int i = 0; i < 40; i++) begin
      b = (i % 2 == 0);
      if (nbits >= 7) run = ((mrx[6] ^ mrx[5]) == b) ? run + 1 : 0;
      mrx = {mrx[5:0], b};
      nbits++;
      send_bit(b);
    end
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL hunt_junk: got %b want 0", locked); end
    gen = 7'h7f;
    for (int i = 0; i < 40 && !exp_lock; i++) begin
      next_gen(b);
      run = ((mrx[6] ^ mrx[5]) == b) ? run + 1 : 0;
      mrx = {mrx[5:0], b};
      if (run >= 16) exp_lock = 1'b1;
      send_bit(b);
      checks++; if (locked !== exp_lock) begin errors++; $display("[TB] FAIL hunt_lock_bit%0d: got %b want %b", i, locked, exp_lock); end
    end
    checks++; if (exp_lock !== 1'b1 || locked !== 1'b1) begin errors++; $display("[TB] FAIL hunt_final: got %b want 1", locked); end
  endtask

  task automatic test_all_zero();
    bit seen;
    pulse_reset();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      send_bit(1'b0);
      if (locked) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL zero_never_lock: got %b want 0", seen); end
    checks++; if (dut.state !== HUNT) begin errors++; $display("[TB] FAIL zero_state: got %0d want HUNT", dut.state); end
  endtask

  task automatic test_reset_mid_locked();
    logic b;
    pulse_reset();
    gen = 7'h7f;
    send_prbs(73);
    checks++; if (bit_count !== 32'd50) begin errors++; $display("[TB] FAIL pre_rst_bits: got %0d want 50", bit_count); end
    next_gen(b);
    rst   = 1'b1;
    bitin = ~b;
    @(posedge clk);
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_locked: got %b want 0", locked); end
    checks++; if (error_pulse !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_pulse: got %b want 0", error_pulse); end
    checks++; if (bit_count !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_bits: got %0d want 0", bit_count); end
    checks++; if (error_count !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_errs: got %0d want 0", error_count); end
    checks++; if (dut.state !== SEED) begin errors++; $display("[TB] FAIL rst_mid_state: got %0d want SEED", dut.state); end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_flips();
    test_clear_on_error();
    test_loss_window();
    test_hunt();
    test_all_zero();
    test_reset_mid_locked();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
